// File: rtl/i2s_rx.sv
// I2S (Philips) receiver: oversamples sclk/lrclk/data in the clk domain and
// emits left/right PCM words with a one-cycle valid strobe per stereo frame.
module i2s_rx #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i2s_sclk,
    input  logic                  lrclk,
    input  logic                  i2s_data,
    output logic [DATA_WIDTH-1:0] left_sample,
    output logic [DATA_WIDTH-1:0] right_sample,
    output logic                  sample_valid
);
    localparam int            CW      = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_LEFT,
        ST_RIGHT
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ws_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   sclk_dly_q;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  sr_q, sr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   ws_prev_q, ws_prev_d;
    logic [DATA_WIDTH-1:0]  left_q, left_d;
    logic [DATA_WIDTH-1:0]  right_q, right_d;
    logic                   valid_q, valid_d;

    logic                   sclk_s, ws_s, bit_s;
    logic                   rise, boundary;
    logic [DATA_WIDTH-1:0]  bit_word, sr_cap;
    logic [CW-1:0]          cnt_cap;

    // All three inputs share one path so their relative alignment survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            ws_sync_q   <= '0;
            data_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i2s_sclk};
            ws_sync_q   <= {ws_sync_q[SYNC_STAGES-2:0], lrclk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], i2s_data};
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign ws_s     = ws_sync_q[SYNC_STAGES-1];
    assign bit_s    = data_sync_q[SYNC_STAGES-1];
    assign rise     = sclk_s & ~sclk_dly_q;
    assign boundary = rise & (ws_s != ws_prev_q);

    // Captured word including the current bit; the boundary bit is the LSB
    // of the outgoing word, so the latch below always uses this value.
    always_comb begin
        bit_word                 = '0;
        bit_word[DATA_WIDTH-1]   = bit_s;
        sr_cap                   = sr_q;
        cnt_cap                  = cnt_q;
        if (cnt_q < CNT_MAX) begin
            sr_cap  = sr_q | (bit_word >> cnt_q);
            cnt_cap = cnt_q + CW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        ws_prev_d = ws_prev_q;
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = 1'b0;

        if (rise) begin
            ws_prev_d = ws_s;
            if (boundary) begin
                sr_d  = '0;
                cnt_d = '0;
            end else begin
                sr_d  = sr_cap;
                cnt_d = cnt_cap;
            end
        end

        case (state_q)
            ST_SYNC: begin
                if (boundary && ws_prev_q && !ws_s) begin
                    state_d = ST_LEFT;
                end
            end
            ST_LEFT: begin
                if (boundary) begin
                    left_d  = sr_cap;
                    state_d = ST_RIGHT;
                end
            end
            ST_RIGHT: begin
                if (boundary) begin
                    right_d = sr_cap;
                    valid_d = 1'b1;
                    state_d = ST_LEFT;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_SYNC;
            sr_q      <= '0;
            cnt_q     <= '0;
            ws_prev_q <= 1'b0;
            left_q    <= '0;
            right_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            ws_prev_q <= ws_prev_d;
            left_q    <= left_d;
            right_q   <= right_d;
            valid_q   <= valid_d;
        end
    end

    assign left_sample  = left_q;
    assign right_sample = right_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Randomized scoreboard bench for i2s_rx: frames are built from slot words,
// expected samples come from a word-level model of left-justified truncation.
module tb_i2s_rx;
    localparam int DW = 16;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i2s_sclk = 1'b0;
    logic          lrclk = 1'b0;
    logic          i2s_data = 1'b0;
    logic [DW-1:0] left_sample;
    logic [DW-1:0] right_sample;
    logic          sample_valid;

    i2s_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .clk          (clk),
        .reset        (reset),
        .i2s_sclk     (i2s_sclk),
        .lrclk        (lrclk),
        .i2s_data     (i2s_data),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_t;

    pair_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    n_exp = 0;
    int    n_got = 0;
    int    cyc = 0;
    int    lsb_cyc = 0;
    int    half = 16;
    bit    model_synced = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Word as seen by a DW-bit MSB-first receiver: truncated or zero-padded.
    function automatic logic [DW-1:0] expect_word(input logic [31:0] v, input int s);
        if (s >= DW) return DW'(v >> (s - DW));
        else         return DW'(v << (DW - s));
    endfunction

    function automatic logic [31:0] slot_mask(input int s);
        if (s >= 32) return 32'hFFFF_FFFF;
        else         return (32'd1 << s) - 32'd1;
    endfunction

    task automatic check_zero_outputs(input string tag);
        checks += 3;
        if (left_sample !== '0) begin
            errors++;
            $display("FAIL %s_left: got %h, required 0000", tag, left_sample);
        end
        if (right_sample !== '0) begin
            errors++;
            $display("FAIL %s_right: got %h, required 0000", tag, right_sample);
        end
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_valid: got %b, required 0", tag, sample_valid);
        end
    endtask

    // One sclk period starting at a negedge of clk; data and ws change while sclk is low.
    task automatic send_bit(input logic ws, input logic b, input bit do_rst, input bit is_rlsb);
        i2s_sclk = 1'b0;
        lrclk    = ws;
        i2s_data = b;
        if (do_rst) begin
            @(negedge clk);
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
            model_synced = 1'b0;
            check_zero_outputs("midreset");
            repeat (half - 3) @(negedge clk);
        end else begin
            repeat (half) @(negedge clk);
        end
        i2s_sclk = 1'b1;
        if (is_rlsb) lsb_cyc = cyc;
        repeat (half) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int s, input int rst_bit);
        bit    ok;
        pair_t e;
        ok = model_synced;
        for (int i = s - 1; i >= 0; i--) begin
            if (i == rst_bit) ok = 1'b0;
            send_bit(i == 0, l[i], i == rst_bit, 1'b0);
        end
        if (ok) begin
            e.l = expect_word(l, s);
            e.r = expect_word(r, s);
            exp_q.push_back(e);
            n_exp++;
        end
        for (int i = s - 1; i >= 0; i--) begin
            send_bit(i != 0, r[i], 1'b0, i == 0);
        end
        model_synced = 1'b1;
    endtask

    // Scoreboard monitor: every pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        pair_t e;
        int    lat;
        if (!reset && sample_valid) begin
            n_got++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got L=%h R=%h, required no pulse", left_sample, right_sample);
            end else begin
                e   = exp_q.pop_front();
                lat = cyc - lsb_cyc;
                checks += 2;
                if (left_sample !== e.l) begin
                    errors++;
                    $display("FAIL left_sample: got %h, required %h", left_sample, e.l);
                end
                if (right_sample !== e.r) begin
                    errors++;
                    $display("FAIL right_sample: got %h, required %h", right_sample, e.r);
                end
                if (lat < SS + 1 || lat > SS + 2) begin
                    errors++;
                    $display("FAIL latency: got %0d clk, required %0d..%0d", lat, SS + 1, SS + 2);
                end
                $display("txn %0d: L=%h R=%h latency=%0d", n_got, left_sample, right_sample, lat);
            end
        end
    end

    initial begin
        int            s;
        logic [31:0]   l, r;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_zero_outputs("reset");

        // Nominal frame at 32 clk per bit: sync frame, then a counted frame.
        half = 16;
        send_frame(32'hA5C3, 32'h1234, 16, -1);
        send_frame(32'hA5C3, 32'h1234, 16, -1);

        half = 4;
        send_frame(32'hABCDEF, 32'h123456, 24, -1);
        send_frame(32'hFFF, 32'h801, 12, -1);

        // Reset in the middle of a left word: that frame is lost.
        send_frame(32'h5A5A, 32'hC3C3, 16, 10);
        send_frame(32'h1357, 32'h2468, 16, -1);

        // Stream starting mid-right-word after a clean reset.
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_synced = 1'b0;
        check_zero_outputs("reset2");
        l = 32'h16;
        for (int i = 4; i >= 0; i--) send_bit(i != 0, l[i], 1'b0, 1'b0);
        model_synced = 1'b1;
        send_frame(32'hBEEF, 32'hCAFE, 16, -1);

        // Randomized slot widths, including 1-bit and over-long slots.
        for (int k = 0; k < 40; k++) begin
            s = $urandom_range(1, 32);
            l = $urandom & slot_mask(s);
            r = $urandom & slot_mask(s);
            send_frame(l, r, s, -1);
        end

        repeat (20) @(negedge clk);
        checks += 2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_valid: got %0d outstanding, required 0", exp_q.size());
        end
        if (n_got != n_exp) begin
            errors++;
            $display("FAIL pulse_count: got %0d, required %0d", n_got, n_exp);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
